// File: rtl/mvagu.sv
// mvagu: multi-loop address generator for one MVU memory bank.
// Walks an NLOOPS-deep nest of signed jumps (loop 0 innermost) from a latched
// base address and streams the addresses over a valid/ready handshake.
// Optional feature macro MVAGU_PLANE_EN adds a bit-plane inner loop that emits
// prec consecutive addresses (base+off+p) for every loop position.
module mvagu #(
    parameter int BWADDR   = 15,
    parameter int BWLENGTH = 8,
    parameter int NLOOPS   = 5,
    parameter int BPREC    = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         start,
    input  logic [BWADDR-1:0]            baseaddr,
    input  logic [NLOOPS*BWADDR-1:0]     jumps,
    input  logic [NLOOPS*BWLENGTH-1:0]   lengths,
    input  logic [BPREC-1:0]             prec,
    output logic                         busy,
    output logic                         done,
    output logic [BWADDR-1:0]            addr_out,
    output logic                         addr_valid,
    input  logic                         addr_ready,
    output logic                         msb,
    output logic                         last,
    output logic [NLOOPS-1:0]            on_j
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [BWLENGTH-1:0] LEN_ONE = BWLENGTH'(1);
    localparam logic [NLOOPS-1:0]   ONJ_ONE = NLOOPS'(1);

    // Smallest loop index whose counter has not yet reached its length.
    function automatic int first_open(
        input logic [NLOOPS*BWLENGTH-1:0] cnt,
        input logic [NLOOPS*BWLENGTH-1:0] len
    );
        int k;
        k = NLOOPS - 1;
        for (int i = NLOOPS - 1; i >= 0; i--) begin
            if (cnt[i*BWLENGTH +: BWLENGTH] != len[i*BWLENGTH +: BWLENGTH]) begin
                k = i;
            end else begin
                k = k;
            end
        end
        return k;
    endfunction

    state_t                       state_r;
    logic [BWADDR-1:0]            base_r;
    logic [NLOOPS*BWADDR-1:0]     jumps_r;
    logic [NLOOPS*BWLENGTH-1:0]   lengths_r;
    logic [NLOOPS*BWLENGTH-1:0]   cnt_r;
    logic [BWADDR-1:0]            off_r;

    int                           step_k_s;
    logic [NLOOPS*BWLENGTH-1:0]   cnt_step_s;
    logic [BWADDR-1:0]            off_step_s;
    logic [NLOOPS-1:0]            onj_step_s;
    logic                         all_max_step_s;

    logic                         hs_s;
    logic                         start_acc_s;
    logic                         finish_s;
    logic                         plane_inc_s;
    logic                         loop_step_s;

    logic                         plane_last_s;
    logic                         plane_next_last_s;
    logic                         start_plane_last_s;
    logic                         pm1_zero_s;

    assign hs_s        = (state_r == ST_RUN) && addr_valid && addr_ready;
    assign start_acc_s = (state_r == ST_IDLE) && start && !clr;
    assign finish_s    = hs_s && last && !clr;
    assign plane_inc_s = hs_s && !last && !plane_last_s && !clr;
    assign loop_step_s = hs_s && !last && plane_last_s && !clr;

`ifdef MVAGU_PLANE_EN
    logic [BPREC-1:0] plane_r;
    logic [BPREC-1:0] pm1_r;
    logic [BPREC-1:0] pm1_s;

    // prec of zero behaves like one plane; keep P-1 for the end-of-plane compare.
    assign pm1_s = (prec == '0) ? '0 : (prec - BPREC'(1));

    // Bit-plane counter: advances on every handshake until the last plane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plane_r <= '0;
            pm1_r   <= '0;
        end else if (clr) begin
            plane_r <= '0;
        end else if (start_acc_s) begin
            plane_r <= '0;
            pm1_r   <= pm1_s;
        end else if (plane_inc_s) begin
            plane_r <= plane_r + BPREC'(1);
        end else if (loop_step_s) begin
            plane_r <= '0;
        end
    end

    assign plane_last_s       = (plane_r == pm1_r);
    assign plane_next_last_s  = ((plane_r + BPREC'(1)) == pm1_r);
    assign start_plane_last_s = (pm1_s == '0);
    assign pm1_zero_s         = (pm1_r == '0);
`else
    logic prec_unused_s;
    assign prec_unused_s      = ^prec;
    assign plane_last_s       = 1'b1;
    assign plane_next_last_s  = 1'b0;
    assign start_plane_last_s = 1'b1;
    assign pm1_zero_s         = 1'b1;
`endif

    // Next loop position: clear the loops below the stepping loop, bump it, add its jump.
    always_comb begin
        step_k_s   = first_open(cnt_r, lengths_r);
        cnt_step_s = cnt_r;
        for (int i = 0; i < NLOOPS; i++) begin
            if (i < step_k_s) begin
                cnt_step_s[i*BWLENGTH +: BWLENGTH] = '0;
            end else if (i == step_k_s) begin
                cnt_step_s[i*BWLENGTH +: BWLENGTH] = cnt_r[i*BWLENGTH +: BWLENGTH] + LEN_ONE;
            end else begin
                cnt_step_s[i*BWLENGTH +: BWLENGTH] = cnt_r[i*BWLENGTH +: BWLENGTH];
            end
        end
        off_step_s     = off_r + jumps_r[step_k_s*BWADDR +: BWADDR];
        onj_step_s     = ONJ_ONE << step_k_s;
        all_max_step_s = (cnt_step_s == lengths_r);
    end

    // Sequencer FSM with registered address/flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            base_r     <= '0;
            jumps_r    <= '0;
            lengths_r  <= '0;
            cnt_r      <= '0;
            off_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_out   <= '0;
            addr_valid <= 1'b0;
            msb        <= 1'b0;
            last       <= 1'b0;
            on_j       <= '0;
        end else if (clr) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start_acc_s) begin
                        state_r    <= ST_RUN;
                        base_r     <= baseaddr;
                        jumps_r    <= jumps;
                        lengths_r  <= lengths;
                        cnt_r      <= '0;
                        off_r      <= '0;
                        busy       <= 1'b1;
                        addr_valid <= 1'b1;
                        addr_out   <= baseaddr;
                        msb        <= 1'b1;
                        last       <= (lengths == '0) && start_plane_last_s;
                        on_j       <= '0;
                    end
                end
                ST_RUN: begin
                    if (finish_s) begin
                        state_r    <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        addr_valid <= 1'b0;
                    end else if (plane_inc_s) begin
                        // Next plane of the same position: address simply increments.
                        addr_out <= addr_out + BWADDR'(1);
                        msb      <= 1'b0;
                        on_j     <= '0;
                        last     <= plane_next_last_s && (cnt_r == lengths_r);
                    end else if (loop_step_s) begin
                        cnt_r    <= cnt_step_s;
                        off_r    <= off_step_s;
                        addr_out <= base_r + off_step_s;
                        msb      <= 1'b1;
                        on_j     <= onj_step_s;
                        last     <= all_max_step_s && pm1_zero_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    addr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mvagu.sv
// tb_mvagu: scoreboard bench for mvagu. Expected addresses come from a
// mixed-radix enumeration of the loop nest; a negedge monitor pops and compares.
module tb_mvagu;

    localparam int AW = 15;
    localparam int LW = 8;
    localparam int NL = 5;
    localparam int PW = 6;
`ifdef MVAGU_PLANE_EN
    localparam bit PLANE_EN = 1'b1;
`else
    localparam bit PLANE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic          m;
        logic          l;
        logic [NL-1:0] j;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     baseaddr = '0;
    logic [NL*AW-1:0]  jumps = '0;
    logic [NL*LW-1:0]  lengths = '0;
    logic [PW-1:0]     prec = '0;
    logic              addr_ready = 1'b1;
    logic              busy, done, addr_valid, msb, last;
    logic [AW-1:0]     addr_out;
    logic [NL-1:0]     on_j;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    bit   rand_ready = 1'b0;
    bit   exp_done = 1'b0;
    bit   exp_idle = 1'b0;
    bit   hold_v = 1'b0;
    exp_t hold_e;

    mvagu dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
        .baseaddr(baseaddr), .jumps(jumps), .lengths(lengths), .prec(prec),
        .busy(busy), .done(done), .addr_out(addr_out), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .msb(msb), .last(last), .on_j(on_j)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: enumerate positions n in mixed radix (lengths[k]+1); the jump
    // taken into position n is that of its lowest nonzero digit.
    task automatic gen_model(input logic [AW-1:0] base, input logic [NL*AW-1:0] jv,
                             input logic [NL*LW-1:0] lv, input logic [PW-1:0] pr);
        int p, total;
        logic [AW-1:0] off;
        exp_t e;
        p = PLANE_EN ? ((pr == 0) ? 1 : int'(pr)) : 1;
        total = 1;
        for (int i = 0; i < NL; i++) total = total * (int'(lv[i*LW +: LW]) + 1);
        off = '0;
        for (int n = 0; n < total; n++) begin
            int k, rem, rad;
            k = -1;
            rem = n;
            if (n > 0) begin
                for (int i = 0; i < NL; i++) begin
                    rad = int'(lv[i*LW +: LW]) + 1;
                    if (k < 0 && (rem % rad) != 0) k = i;
                    rem = rem / rad;
                end
                off = off + jv[k*AW +: AW];
            end
            for (int q = 0; q < p; q++) begin
                e.a = base + off + AW'(q);
                e.m = (q == 0);
                e.l = (n == total - 1) && (q == p - 1);
                e.j = (q == 0 && k >= 0) ? (NL'(1) << k) : '0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Consumer-side ready: random 50% duty or constantly high.
    always @(posedge clk) begin
        #1 addr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: stall stability, handshake scoreboard and done-pulse timing.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v   = 1'b0;
            exp_done = 1'b0;
            exp_idle = 1'b0;
        end else begin
            if (exp_idle) begin
                chk("done_low_after_pulse", done, 0);
                exp_idle = 1'b0;
            end
            if (exp_done) begin
                chk("done_pulse", done, 1);
                chk("done_busy_low", busy, 0);
                chk("done_valid_low", addr_valid, 0);
                exp_done = 1'b0;
                exp_idle = 1'b1;
            end
            if (done) done_cnt++;
            if (hold_v && addr_valid) begin
                chk("stall_addr", addr_out, hold_e.a);
                chk("stall_msb", msb, hold_e.m);
                chk("stall_last", last, hold_e.l);
                chk("stall_onj", on_j, hold_e.j);
            end
            hold_v   = addr_valid && !addr_ready && !clr;
            hold_e.a = addr_out;
            hold_e.m = msb;
            hold_e.l = last;
            hold_e.j = on_j;
            if (addr_valid && addr_ready && !clr && !start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", addr_out, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("addr", addr_out, e.a);
                    chk("msb", msb, e.m);
                    chk("last", last, e.l);
                    chk("on_j", on_j, e.j);
                    if (e.l) exp_done = 1'b1;
                end
            end else if (addr_valid && addr_ready && !clr) begin
                exp_t e;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("addr", addr_out, e.a);
                    if (e.l) exp_done = 1'b1;
                end
            end
        end
    end

    task automatic run_seq(input logic [AW-1:0] base, input logic [NL*AW-1:0] jv,
                           input logic [NL*LW-1:0] lv, input logic [PW-1:0] pr,
                           input bit rnd, input bit poke);
        int dc0, cyc;
        rand_ready = rnd;
        baseaddr = base;
        jumps = jv;
        lengths = lv;
        prec = pr;
        gen_model(base, jv, lv, pr);
        dc0 = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_valid", addr_valid, 1);
        cyc = 0;
        while (done_cnt == dc0 && cyc < 6000) begin
            @(posedge clk);
            #1 cyc++;
            if (poke && cyc == 3) begin
                start = 1'b1;
                baseaddr = base ^ 15'h1234;
                jumps = {$urandom, $urandom, $urandom};
                lengths = {$urandom, $urandom};
                prec = 6'd7;
            end
            if (poke && cyc == 4) start = 1'b0;
        end
        if (done_cnt == dc0) chk("done_timeout", 0, 1);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NL*LW-1:0] rand_lens();
        logic [NL*LW-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[i*LW +: LW] = LW'($urandom_range(0, 2));
        return v;
    endfunction

    initial begin
        logic [NL*AW-1:0] jv;
        logic [NL*LW-1:0] lv;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", addr_valid, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_msb", msb, 0);
        chk("rst_last", last, 0);
        chk("rst_onj", on_j, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed two-loop nest: 100,101,111,112,122,123.
        jv = '0; jv[0 +: AW] = 15'd1; jv[AW +: AW] = 15'd10;
        lv = '0; lv[0 +: LW] = 8'd1; lv[LW +: LW] = 8'd2;
        run_seq(15'd100, jv, lv, 6'd1, 1'b0, 1'b0);
        // Same nest with three bit-planes per position.
        run_seq(15'd100, jv, lv, 6'd3, 1'b0, 1'b0);
        // Same nest under random back-pressure.
        run_seq(15'd100, jv, lv, 6'd3, 1'b1, 1'b0);
        // prec=0 behaves as one plane.
        run_seq(15'd100, jv, lv, 6'd0, 1'b0, 1'b0);

        // Negative jump wraps: 0, 0x7FFF, 0x7FFE.
        jv = '0; jv[0 +: AW] = 15'h7FFF;
        lv = '0; lv[0 +: LW] = 8'd2;
        run_seq(15'd0, jv, lv, 6'd1, 1'b0, 1'b0);

        // Single-address sequence (all lengths zero).
        run_seq(15'h7FFF, '0, '0, 6'd1, 1'b0, 1'b0);

        // Start while busy with a different config is ignored.
        jv = {5{15'd3}};
        lv = '0; lv[0 +: LW] = 8'd4; lv[LW +: LW] = 8'd3;
        run_seq(15'd500, jv, lv, 6'd1, 1'b0, 1'b1);

        // Randomized configurations.
        for (int t = 0; t < 6; t++) begin
            run_seq(AW'($urandom), {$urandom, $urandom, $urandom}, rand_lens(),
                    PW'($urandom_range(0, 4)), bit'(t % 2), 1'b0);
        end

        // clr after the third handshake: no done, then a clean restart.
        jv = '0; jv[0 +: AW] = 15'd2;
        lv = '0; lv[0 +: LW] = 8'd9;
        baseaddr = 15'd40; jumps = jv; lengths = lv; prec = 6'd1;
        gen_model(15'd40, jv, lv, 6'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        chk("clr_valid", addr_valid, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        exp_q.delete();
        repeat (3) begin
            @(posedge clk);
            #1 chk("clr_no_done", done, 0);
        end
        run_seq(15'd40, jv, lv, 6'd1, 1'b0, 1'b0);

        // clr together with start drops the start.
        start = 1'b1; clr = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; clr = 1'b0;
        chk("clr_start_busy", busy, 0);
        chk("clr_start_valid", addr_valid, 0);

        // Asynchronous reset mid-run.
        gen_model(15'd40, jv, lv, 6'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", addr_valid, 0);
        chk("arst_addr", addr_out, 0);
        chk("arst_msb", msb, 0);
        chk("arst_last", last, 0);
        chk("arst_onj", on_j, 0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_seq(15'd40, jv, lv, 6'd1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mvagu.md
# mvagu

Parametrised multi-loop address generator for the MVU datapath, successor to the fixed five-jump input/weight AGU. It walks an NLOOPS-deep nested loop of signed jumps over one memory bank, optionally interleaving a bit-plane (precision) inner loop, and streams addresses over a valid/ready handshake. A start/busy/done handshake lets the controller run one complete sequence per command; one instance serves either the data bank or the weight bank.

## Interface
- BWADDR, 15, address width; all address arithmetic is modulo 2^BWADDR.
- BWLENGTH, 8, width of each loop length.
- NLOOPS, 5, number of nested loops; loop 0 is innermost.
- BPREC, 6, width of the precision field.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous abort; overrides start.
- start  in  1  command strobe; sampled only in IDLE.
- baseaddr  in  BWADDR  base address, latched at start.
- jumps  in  NLOOPS*BWADDR  jump k at [k*BWADDR +: BWADDR], two's complement, latched at start.
- lengths  in  NLOOPS*BWLENGTH  length k at [k*BWLENGTH +: BWLENGTH]; loop k runs lengths[k]+1 times; latched at start.
- prec  in  BPREC  bit-planes per position; 0 is treated as 1; latched at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final address handshake.
- addr_out  out  BWADDR  current address.
- addr_valid  out  1  addr_out is valid.
- addr_ready  in  1  consumer accepts addr_out.
- msb  out  1  current address is the MSB plane (plane offset 0).
- last  out  1  current address is the final address of the sequence.
- on_j  out  NLOOPS  one-hot; bit k set if this position was reached via jump k. Zero on the first position and on non-first planes.

## Operation
- State machine: IDLE -> RUN on start. RUN -> DONE on a handshake (addr_valid && addr_ready) while last=1. DONE -> IDLE unconditionally; done is high in DONE. Any state -> IDLE on clr.
- In RUN:
  - Counters: c[0..NLOOPS-1], plane counter p, offset register off.
  - Output relation: addr_out = baseaddr + off + p, truncated to BWADDR; msb = (p==0).
- On each handshake, with P = max(prec,1):
  - If p < P-1: p++, and no loop counter moves.
  - Otherwise p=0, and the loops step. Pick the smallest k with c[k] != lengths[k]. Clear c[0..k-1], increment c[k], set off += jumps[k], and assert on_j[k] on the new position.
- last = (p == P-1) && every c[k] == lengths[k].
- Sequence length is P * prod(lengths[k]+1) addresses, each emitted exactly once and in order.
- start while busy is ignored; the latched config is unaffected by input changes after start.
- Overflow of off or addr_out wraps silently.

## Timing
- Reset values: busy=0, done=0, addr_valid=0, addr_out=0, msb=0, last=0, on_j=0; FSM=IDLE; all counters 0.
- All outputs are registered.
- Start latency: start high in IDLE at edge N gives busy=1, addr_valid=1, and first address (baseaddr, msb=1) after edge N.
- Throughput: one address per cycle while addr_ready=1.
- Handshake: with addr_valid=1 and addr_ready=0, addr_out, msb, last and on_j are held stable. addr_valid never drops in RUN without a handshake.
- Completion: on the final handshake at edge M, addr_valid=0, busy=0 and done=1 after edge M. done=0 and the block is in IDLE after edge M+1. start is accepted in the IDLE cycle that follows.
- clr at edge N: addr_valid=0, busy=0 and done=0 after edge N; no done pulse is produced. clr in the same cycle as start: start is dropped.
- rst_n asserted mid-sequence: outputs go to reset values immediately, without waiting for a clock edge.

## Configuration
- MVAGU_PLANE_EN defined: bit-plane inner loop as described above.
- MVAGU_PLANE_EN undefined:
  - prec is ignored and P=1; no p register is built.
  - addr_out = baseaddr + off; msb is constant 1.
  - Loop stepping happens on every handshake.

## Test plan
- NLOOPS=2, lengths={1,2}, jumps={1,10}, base=100, prec=1, ready=1 -> 100,101,111,112,122,123. on_j on addresses 2..6 = 01,10,01,10,01. last on 123. done one cycle later.
- Same config, prec=3 (plane enabled) -> 18 addresses starting 100,101,102,101,102,103,... msb on every third address. on_j only on the plane-0 address of each position.
- Random addr_ready toggling, 50% duty -> outputs stable while stalled; the emitted sequence matches the ready=1 case exactly.
- jumps[0]=0x7FFF (i.e. -1), base=0, lengths={2} -> addresses 0, 0x7FFF, 0x7FFE (wrap).
- clr asserted after the 3rd handshake -> addr_valid=0 and busy=0 next cycle, no done. A new start then restarts from baseaddr.
- start while busy with different base -> ignored; sequence unchanged. rst_n low mid-run -> immediate reset values.
